// File: rtl/pc_gen_multi_if.sv
// Redirect/fetch bundle between the redirect sources and the IF-stage PC generator.
// slave = PC generator side, master = stimulus/redirect side.
interface pc_gen_multi_if #(
   parameter int ADDR_W    = 32,
   parameter int NUM_REDIR = 4
);
   localparam int SRC_W = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;

   logic                        stall;
   logic [NUM_REDIR-1:0]        redir_valid;
   logic [NUM_REDIR*ADDR_W-1:0] redir_pc;
   logic [ADDR_W-1:0]           pc;
   logic                        pc_valid;
   logic                        redir_pending;
   logic [SRC_W-1:0]            redir_src;
   logic                        pc_misalign;

   modport master (
      output stall, redir_valid, redir_pc,
      input  pc, pc_valid, redir_pending, redir_src, pc_misalign
   );

   modport slave (
      input  stall, redir_valid, redir_pc,
      output pc, pc_valid, redir_pending, redir_src, pc_misalign
   );
endinterface

// File: rtl/pc_gen_multi.sv
// IF-stage PC generator: prioritised redirects, stall-time latching, fetch bubble.
// Optional PC_MISALIGN_CHK_EN adds a registered misaligned-target flag.
module pc_gen_multi #(
   parameter int               ADDR_W       = 32,
   parameter logic [ADDR_W-1:0] RESET_PC    = 32'h1c00_0000,
   parameter int               NUM_REDIR    = 4,
   parameter int               FETCH_BYTES  = 4,
   parameter int               REDIR_BUBBLE = 0
) (
   input logic            cpu_clk,
   input logic            cpu_rst,
   pc_gen_multi_if.slave  bus
);
   localparam int SRC_W = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;
   localparam logic [2:0]        BUB = 3'(REDIR_BUBBLE);
   localparam logic [ADDR_W-1:0] INC = ADDR_W'(FETCH_BYTES);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pend_pc_q;
   logic [SRC_W-1:0]  src_q;
   logic [SRC_W-1:0]  pend_idx_q;
   logic              pend_q;
   logic              valid_q;
   logic [2:0]        cnt_q;

   logic              win_vld;
   logic [SRC_W-1:0]  win_idx;
   logic [ADDR_W-1:0] win_pc;
   logic              live_ok;
   logic              first;
   logic              apply;
   logic [ADDR_W-1:0] tgt;
   logic [SRC_W-1:0]  tgt_idx;

   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      win_pc  = '0;
      for (int i = NUM_REDIR - 1; i >= 0; i--) begin
         if (bus.redir_valid[i]) begin
            win_vld = 1'b1;
            win_idx = SRC_W'(i);
            win_pc  = bus.redir_pc[i*ADDR_W +: ADDR_W];
         end
      end
   end

   // Invalid with an idle counter only happens before the first edge after reset.
   assign first   = !valid_q && (cnt_q == 3'd0);
   assign live_ok = win_vld && (!pend_q || (win_idx <= pend_idx_q));
   assign apply   = !first && !bus.stall && (live_ok || pend_q);
   assign tgt     = live_ok ? win_pc  : pend_pc_q;
   assign tgt_idx = live_ok ? win_idx : pend_idx_q;

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         pc_q       <= RESET_PC;
         pend_pc_q  <= '0;
         src_q      <= '0;
         pend_idx_q <= '0;
         pend_q     <= 1'b0;
         valid_q    <= 1'b0;
         cnt_q      <= 3'd0;
      end else if (first) begin
         valid_q <= 1'b1;
      end else if (bus.stall) begin
         if (live_ok) begin
            pend_q     <= 1'b1;
            pend_pc_q  <= win_pc;
            pend_idx_q <= win_idx;
         end
      end else if (apply) begin
         pc_q    <= tgt;
         src_q   <= tgt_idx;
         pend_q  <= 1'b0;
         cnt_q   <= BUB;
         valid_q <= (BUB == 3'd0);
      end else if (cnt_q != 3'd0) begin
         cnt_q   <= cnt_q - 3'd1;
         valid_q <= (cnt_q == 3'd1);
      end else begin
         pc_q    <= pc_q + INC;
         valid_q <= 1'b1;
      end
   end

`ifdef PC_MISALIGN_CHK_EN
   localparam int OFF_W = (FETCH_BYTES > 1) ? $clog2(FETCH_BYTES) : 1;
   logic mis_q;

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         mis_q <= 1'b0;
      end else if (apply) begin
         mis_q <= |tgt[OFF_W-1:0];
      end
   end

   assign bus.pc_misalign = mis_q;
`else
   assign bus.pc_misalign = 1'b0;
`endif

   assign bus.pc            = pc_q;
   assign bus.pc_valid      = valid_q;
   assign bus.redir_pending = pend_q;
   assign bus.redir_src     = src_q;
endmodule

// File: tb/tb_pc_gen_multi.sv
// Self-checking bench for pc_gen_multi: two instances (bubble 0 and bubble 2)
// driven by shared stimulus and compared against a cycle-level behavioural model.
module tb_pc_gen_multi;
   localparam logic [31:0] RST_PC = 32'h1c00_0000;

   logic         cpu_clk;
   logic         cpu_rst;
   logic         stall;
   logic [3:0]   rv;
   logic [127:0] rpc;

   int n_chk;
   int n_fail;

   pc_gen_multi_if #(.ADDR_W(32), .NUM_REDIR(4)) if0 ();
   pc_gen_multi_if #(.ADDR_W(32), .NUM_REDIR(4)) if2 ();

   assign if0.stall       = stall;
   assign if0.redir_valid = rv;
   assign if0.redir_pc    = rpc;
   assign if2.stall       = stall;
   assign if2.redir_valid = rv;
   assign if2.redir_pc    = rpc;

   pc_gen_multi #(.REDIR_BUBBLE(0)) u_dut0 (
      .cpu_clk (cpu_clk),
      .cpu_rst (cpu_rst),
      .bus     (if0)
   );

   pc_gen_multi #(.REDIR_BUBBLE(2)) u_dut2 (
      .cpu_clk (cpu_clk),
      .cpu_rst (cpu_rst),
      .bus     (if2)
   );

   logic [31:0] o_pc [2];
   logic        o_val[2];
   logic        o_pnd[2];
   logic [1:0]  o_src[2];
   logic        o_mis[2];

   assign o_pc[0]  = if0.pc;
   assign o_val[0] = if0.pc_valid;
   assign o_pnd[0] = if0.redir_pending;
   assign o_src[0] = if0.redir_src;
   assign o_mis[0] = if0.pc_misalign;
   assign o_pc[1]  = if2.pc;
   assign o_val[1] = if2.pc_valid;
   assign o_pnd[1] = if2.redir_pending;
   assign o_src[1] = if2.redir_src;
   assign o_mis[1] = if2.pc_misalign;

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   // Reference model state, one slot per instance
   int          bub[2];
   logic [31:0] m_pc[2];
   logic [31:0] m_ptgt[2];
   bit          m_val[2];
   bit          m_pnd[2];
   bit          m_mis[2];
   bit          m_started[2];
   int          m_src[2];
   int          m_pidx[2];
   int          m_cnt[2];

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         m_pc[k] = RST_PC; m_ptgt[k] = 0; m_val[k] = 0; m_pnd[k] = 0;
         m_mis[k] = 0; m_started[k] = 0; m_src[k] = 0; m_pidx[k] = 0;
         m_cnt[k] = 0;
      end
   endfunction

   function automatic void model_apply(int k, int i, logic [31:0] t);
      m_pc[k]  = t;
      m_src[k] = i;
      m_pnd[k] = 0;
      m_cnt[k] = bub[k];
      m_val[k] = (bub[k] == 0);
`ifdef PC_MISALIGN_CHK_EN
      m_mis[k] = (t[1:0] != 2'b00);
`else
      m_mis[k] = 0;
`endif
   endfunction

   function automatic void model_edge();
      int w;
      bit live;
      w = -1;
      for (int i = 0; i < 4; i++) if (rv[i] && w < 0) w = i;
      for (int k = 0; k < 2; k++) begin
         live = (w >= 0) && (!m_pnd[k] || w <= m_pidx[k]);
         if (!m_started[k]) begin
            m_started[k] = 1;
            m_val[k] = 1;
         end else if (stall) begin
            if (live) begin
               m_pnd[k] = 1; m_pidx[k] = w; m_ptgt[k] = rpc[w*32 +: 32];
            end
         end else if (live) begin
            model_apply(k, w, rpc[w*32 +: 32]);
         end else if (m_pnd[k]) begin
            model_apply(k, m_pidx[k], m_ptgt[k]);
         end else if (m_cnt[k] > 0) begin
            m_cnt[k]--;
            m_val[k] = (m_cnt[k] == 0);
         end else begin
            m_pc[k] = m_pc[k] + 32'd4;
            m_val[k] = 1;
         end
      end
   endfunction

   task automatic tick();
      model_edge();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic set_ch(int i, logic [31:0] t);
      rpc[i*32 +: 32] = t;
   endtask

   task automatic test_reset();
      cpu_rst = 1; stall = 0; rv = 0; rpc = '0;
      model_reset();
      #12;
      for (int k = 0; k < 2; k++) begin
         n_chk++;
         if (o_pc[k] !== RST_PC || o_val[k] !== 1'b0 || o_pnd[k] !== 1'b0 ||
             o_src[k] !== 2'd0 || o_mis[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset[%0d]: pc=%h val=%b pnd=%b src=%0d mis=%b, want %h 0 0 0 0",
                     k, o_pc[k], o_val[k], o_pnd[k], o_src[k], o_mis[k], RST_PC);
         end
      end
      @(negedge cpu_clk);
      cpu_rst = 0;
      tick();
      for (int k = 0; k < 2; k++) begin
         n_chk++;
         if (o_pc[k] !== RST_PC || o_val[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL first_edge[%0d]: pc=%h val=%b, want %h 1", k, o_pc[k], o_val[k], RST_PC);
         end
      end
      tick();
      n_chk++;
      if (o_pc[0] !== 32'h1c00_0004) begin
         n_fail++; $display("FAIL seq1: pc=%h, want 1c000004", o_pc[0]);
      end
      tick();
      n_chk++;
      if (o_pc[1] !== 32'h1c00_0008) begin
         n_fail++; $display("FAIL seq2: pc=%h, want 1c000008", o_pc[1]);
      end
   endtask

   task automatic test_same_edge();
      rv = 4'b1010; set_ch(1, 32'h100); set_ch(3, 32'h200);
      tick();
      rv = 0;
      n_chk++;
      if (o_pc[0] !== 32'h100 || o_src[0] !== 2'd1 || o_val[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL same_edge: pc=%h src=%0d val=%b, want 100 1 1", o_pc[0], o_src[0], o_val[0]);
      end
      n_chk++;
      if (o_pc[1] !== 32'h100 || o_val[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL same_edge_bub: pc=%h val=%b, want 100 0", o_pc[1], o_val[1]);
      end
   endtask

   task automatic test_stall_latch();
      logic [31:0] hold;
      hold = o_pc[0];
      stall = 1; rv = 4'b0100; set_ch(2, 32'h300);
      tick();
      rv = 0;
      n_chk++;
      if (o_pnd[0] !== 1'b1 || o_pc[0] !== hold) begin
         n_fail++;
         $display("FAIL stall_latch: pnd=%b pc=%h, want 1 %h", o_pnd[0], o_pc[0], hold);
      end
      tick();
      rv = 4'b0001; set_ch(0, 32'h400);
      tick();
      rv = 0;
      tick();
      n_chk++;
      if (o_pnd[1] !== 1'b1) begin
         n_fail++; $display("FAIL stall_pend_bub: pnd=%b, want 1", o_pnd[1]);
      end
      stall = 0;
      tick();
      for (int k = 0; k < 2; k++) begin
         n_chk++;
         if (o_pc[k] !== 32'h400 || o_src[k] !== 2'd0 || o_pnd[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release[%0d]: pc=%h src=%0d pnd=%b, want 400 0 0",
                     k, o_pc[k], o_src[k], o_pnd[k]);
         end
      end
   endtask

   task automatic test_bubble();
      logic [2:0] want_v;
      want_v = 3'b100;
      repeat (3) tick();
      rv = 4'b0001; set_ch(0, 32'h80);
      tick();
      rv = 0;
      for (int c = 0; c < 3; c++) begin
         n_chk++;
         if (o_pc[1] !== 32'h80 || o_val[1] !== want_v[c]) begin
            n_fail++;
            $display("FAIL bubble c%0d: pc=%h val=%b, want 80 %b", c, o_pc[1], o_val[1], want_v[c]);
         end
         tick();
      end
      n_chk++;
      if (o_pc[1] !== 32'h84 || o_val[1] !== 1'b1 || o_pc[0] !== 32'h8c) begin
         n_fail++;
         $display("FAIL bubble_done: pc2=%h val=%b pc0=%h, want 84 1 8c", o_pc[1], o_val[1], o_pc[0]);
      end
   endtask

   task automatic test_wrap();
      rv = 4'b1000; set_ch(3, 32'hffff_fff8);
      tick();
      rv = 0;
      tick();
      n_chk++;
      if (o_pc[0] !== 32'hffff_fffc) begin
         n_fail++; $display("FAIL wrap_pre: pc=%h, want fffffffc", o_pc[0]);
      end
      tick();
      n_chk++;
      if (o_pc[0] !== 32'h0 || o_src[0] !== 2'd3 || o_pnd[0] !== 1'b0 || o_val[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap: pc=%h src=%0d pnd=%b val=%b, want 0 3 0 1",
                  o_pc[0], o_src[0], o_pnd[0], o_val[0]);
      end
   endtask

   task automatic test_release_prio();
      stall = 1; rv = 4'b0010; set_ch(1, 32'h500);
      tick();
      rv = 4'b0100; set_ch(2, 32'h600);
      tick();
      stall = 0; rv = 4'b1000; set_ch(3, 32'h700);
      tick();
      rv = 0;
      n_chk++;
      if (o_pc[0] !== 32'h500 || o_src[0] !== 2'd1 || o_pnd[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL pend_wins: pc=%h src=%0d pnd=%b, want 500 1 0", o_pc[0], o_src[0], o_pnd[0]);
      end
      stall = 1; rv = 4'b0100; set_ch(2, 32'h900);
      tick();
      stall = 0; set_ch(2, 32'ha00);
      tick();
      rv = 0;
      n_chk++;
      if (o_pc[0] !== 32'ha00 || o_src[0] !== 2'd2 || o_pnd[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL live_wins: pc=%h src=%0d pnd=%b, want a00 2 0", o_pc[0], o_src[0], o_pnd[0]);
      end
   endtask

   task automatic test_misalign();
      logic exp_mis;
`ifdef PC_MISALIGN_CHK_EN
      exp_mis = 1'b1;
`else
      exp_mis = 1'b0;
`endif
      rv = 4'b0001; set_ch(0, 32'h102);
      tick();
      rv = 0;
      n_chk++;
      if (o_pc[0] !== 32'h102 || o_mis[0] !== exp_mis) begin
         n_fail++;
         $display("FAIL misalign: pc=%h mis=%b, want 102 %b", o_pc[0], o_mis[0], exp_mis);
      end
      rv = 4'b0001; set_ch(0, 32'h200);
      tick();
      rv = 0;
      n_chk++;
      if (o_mis[0] !== 1'b0) begin
         n_fail++; $display("FAIL misalign_clr: mis=%b, want 0", o_mis[0]);
      end
   endtask

   task automatic test_random();
      logic [31:0] t;
      for (int c = 0; c < 400; c++) begin
         stall = ($urandom_range(0, 3) == 0);
         rv = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0;
         for (int i = 0; i < 4; i++) begin
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            set_ch(i, t);
         end
         tick();
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (o_pc[k] !== m_pc[k] || o_val[k] !== m_val[k] || o_pnd[k] !== m_pnd[k] ||
                o_src[k] !== 2'(m_src[k]) || o_mis[k] !== m_mis[k]) begin
               n_fail++;
               $display("FAIL random c%0d[%0d]: pc=%h val=%b pnd=%b src=%0d mis=%b, want %h %b %b %0d %b",
                        c, k, o_pc[k], o_val[k], o_pnd[k], o_src[k], o_mis[k],
                        m_pc[k], m_val[k], m_pnd[k], m_src[k], m_mis[k]);
            end
         end
      end
      stall = 0; rv = 0;
   endtask

   task automatic test_reset_mid();
      repeat (2) tick();
      rv = 4'b0001; set_ch(0, 32'h40);
      tick();
      stall = 1; rv = 4'b0010; set_ch(1, 32'h50);
      tick();
      rv = 0;
      n_chk++;
      if (o_pnd[1] !== 1'b1 || o_val[1] !== 1'b0) begin
         n_fail++; $display("FAIL pre_rst: pnd=%b val=%b, want 1 0", o_pnd[1], o_val[1]);
      end
      #2;
      cpu_rst = 1;
      #1;
      model_reset();
      for (int k = 0; k < 2; k++) begin
         n_chk++;
         if (o_pc[k] !== RST_PC || o_pnd[k] !== 1'b0 || o_val[k] !== 1'b0 || o_src[k] !== 2'd0) begin
            n_fail++;
            $display("FAIL async_rst[%0d]: pc=%h pnd=%b val=%b src=%0d, want %h 0 0 0",
                     k, o_pc[k], o_pnd[k], o_val[k], o_src[k], RST_PC);
         end
      end
      stall = 0;
      @(negedge cpu_clk);
      cpu_rst = 0;
      tick();
      tick();
      for (int k = 0; k < 2; k++) begin
         n_chk++;
         if (o_pc[k] !== 32'h1c00_0004 || o_val[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL post_rst[%0d]: pc=%h val=%b, want 1c000004 1", k, o_pc[k], o_val[k]);
         end
      end
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      bub[0] = 0;
      bub[1] = 2;
      test_reset();
      test_same_edge();
      test_stall_latch();
      test_bubble();
      test_wrap();
      test_release_prio();
      test_misalign();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
